if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID-stage decoder.

---
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, redirects, load-use stall and bubbles.
// Optional redirect-misalignment detection is enabled by defining IF_MISALIGN_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JrTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] InstAddr,
  input  logic [31:0] InstData,
  output logic [31:0] IF_ID_Inst,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        MisalignErr
);

`ifdef IF_MISALIGN_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] pcp4_reg, pcp4_next;
  logic        valid_reg, valid_next;
  logic        err_reg, err_next;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;

  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    pcp4_next  = pcp4_reg;
    valid_next = valid_reg;
    redirect   = 1'b0;
    target     = pc_plus4;
    // The branch in EX belongs to an older instruction, so it beats both stall and jumps.
    if (BranchTaken) begin
      redirect = 1'b1;
      target   = BranchTarget;
    end else if (!Stall) begin
      if (valid_reg && PCSrc == 2'b01) begin
        redirect = 1'b1;
        target   = JumpTarget;
      end else if (valid_reg && PCSrc == 2'b10) begin
        redirect = 1'b1;
        target   = JrTarget;
      end else begin
        pc_next    = pc_plus4;
        inst_next  = InstData;
        pcp4_next  = pc_plus4;
        valid_next = 1'b1;
      end
    end
    if (redirect) begin
      pc_next    = {target[31:2], 2'b00};
      inst_next  = NOP_INST;
      pcp4_next  = 32'd0;
      valid_next = 1'b0;
    end
    err_next = err_reg | (CHECK_EN & redirect & (target[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= {RESET_PC[31:2], 2'b00};
      inst_reg  <= NOP_INST;
      pcp4_reg  <= 32'd0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      pcp4_reg  <= pcp4_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  assign InstAddr      = pc_reg;
  assign IF_ID_Inst    = inst_reg;
  assign IF_ID_PCPlus4 = pcp4_reg;
  assign IF_ID_Valid   = valid_reg;
  assign MisalignErr   = err_reg;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, reset corner cases, randomized run vs reference model.
module tb_if_stage;

`ifdef IF_MISALIGN_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pcsrc;
  logic [31:0] jump_target, jr_target, branch_target, inst_data;
  logic        branch_taken;
  logic [31:0] inst_addr, if_id_inst, if_id_pcp4;
  logic        if_id_valid, misalign_err;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .Stall(stall), .PCSrc(pcsrc),
    .JumpTarget(jump_target), .JrTarget(jr_target),
    .BranchTaken(branch_taken), .BranchTarget(branch_target),
    .InstAddr(inst_addr), .InstData(inst_data),
    .IF_ID_Inst(if_id_inst), .IF_ID_PCPlus4(if_id_pcp4),
    .IF_ID_Valid(if_id_valid), .MisalignErr(misalign_err)
  );

  // Reference model state: the architectural view of the fetch stage
  logic [31:0] m_pc, m_inst, m_pcp4;
  logic        m_valid, m_err;

  typedef struct {
    logic        st;
    logic [1:0]  ps;
    logic [31:0] jt, jrt;
    logic        br;
    logic [31:0] bt, ins;
    logic [31:0] e_pc, e_inst, e_pcp4;
    logic        e_valid, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic st, input logic [1:0] ps, input logic [31:0] jt, jrt,
                         input logic br, input logic [31:0] bt, ins,
                         input logic [31:0] e_pc, e_inst, e_pcp4,
                         input logic e_valid, e_err);
    vec_t v;
    v.st = st; v.ps = ps; v.jt = jt; v.jrt = jrt; v.br = br; v.bt = bt; v.ins = ins;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_pcp4 = e_pcp4; v.e_valid = e_valid; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, exp);
    end
  endtask

  task automatic check_all(input logic [31:0] e_pc, e_inst, e_pcp4, input logic e_valid, e_err);
    chk("inst_addr", inst_addr, e_pc);
    chk("if_id_inst", if_id_inst, e_inst);
    chk("if_id_pcplus4", if_id_pcp4, e_pcp4);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e_valid});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, e_err});
  endtask

  // Next architectural state from the current state and this cycle's inputs
  task automatic model_step();
    logic [31:0] tgt;
    logic        jump;
    jump = m_valid && (pcsrc == 2'd1 || pcsrc == 2'd2);
    if (reset) begin
      m_pc = 32'd0; m_inst = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0; m_err = 1'b0;
    end else if (branch_taken || (!stall && jump)) begin
      tgt = branch_taken ? branch_target : (pcsrc == 2'd1 ? jump_target : jr_target);
      if (tgt % 4 != 0) m_err = ERR_EN;
      m_pc = tgt - (tgt % 4);
      m_inst = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0;
    end else if (!stall) begin
      m_inst = inst_data;
      m_pc = m_pc + 32'd4;
      m_pcp4 = m_pc;
      m_valid = 1'b1;
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic [1:0] ps,
                      input logic [31:0] jt, jrt, input logic br, input logic [31:0] bt, ins);
    reset = rst; stall = st; pcsrc = ps; jump_target = jt; jr_target = jrt;
    branch_taken = br; branch_target = bt; inst_data = ins;
    model_step();
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rst=%b stall=%b pcsrc=%0d br=%b -> pc=%h inst=%h pcp4=%h valid=%b err=%b",
             txn, rst, st, ps, br, inst_addr, if_id_inst, if_id_pcp4, if_id_valid, misalign_err);
  endtask

  initial begin
    logic [31:0] t1, t2, t3;
    m_pc = 0; m_inst = 0; m_pcp4 = 0; m_valid = 0; m_err = 0;

    step(1, 0, 0, 0, 0, 0, 0, 32'h2008_0001);
    step(1, 0, 0, 0, 0, 0, 0, 32'h2008_0001);
    check_all(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // inputs: st ps jt jrt br bt ins | expected: pc inst pcp4 valid err
    add_vec(0, 0, 0, 0, 0, 0, 32'h2008_0001, 32'h4, 32'h2008_0001, 32'h4, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 32'h2008_0001, 32'h8, 32'h2008_0001, 32'h8, 1, 0);
    add_vec(0, 1, 32'h40, 0, 0, 0, 32'h2008_0001, 32'h40, 32'h0, 32'h0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 32'hAAAA_0040, 32'h44, 32'hAAAA_0040, 32'h44, 1, 0);
    add_vec(0, 2, 0, 32'h10, 0, 0, 32'h5555_0044, 32'h10, 32'h0, 32'h0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 32'h1111_0010, 32'h10, 32'h0, 32'h0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 32'h1111_0010, 32'h10, 32'h0, 32'h0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 32'h1111_0010, 32'h14, 32'h1111_0010, 32'h14, 1, 0);
    add_vec(1, 1, 32'h900, 0, 0, 0, 32'hDEAD_BEEF, 32'h14, 32'h1111_0010, 32'h14, 1, 0);
    add_vec(1, 2, 0, 32'h500, 1, 32'h100, 32'hDEAD_BEEF, 32'h100, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 32'h800, 0, 0, 0, 32'h2222_0100, 32'h104, 32'h2222_0100, 32'h104, 1, 0);
    add_vec(0, 3, 32'h800, 32'h900, 0, 0, 32'h3333_0104, 32'h108, 32'h3333_0104, 32'h108, 1, 0);
    add_vec(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h4444_0108, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 32'h6666_FFFC, 32'h0, 32'h6666_FFFC, 32'h0, 1, 0);
    add_vec(0, 2, 0, 32'h203, 0, 0, 32'h7777_0000, 32'h200, 32'h0, 32'h0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 0, 32'h8888_0200, 32'h204, 32'h8888_0200, 32'h204, 1, 1);

    foreach (vecs[i]) begin
      step(0, vecs[i].st, vecs[i].ps, vecs[i].jt, vecs[i].jrt, vecs[i].br, vecs[i].bt, vecs[i].ins);
      check_all(vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_pcp4, vecs[i].e_valid, vecs[i].e_err & ERR_EN);
    end

    // Reset during a stall plus branch: everything returns to reset values, sticky flag cleared
    step(1, 1, 2, 0, 32'h600, 1, 32'h300, 32'h9999_0000);
    check_all(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 32'hABCD_0000);
    check_all(32'h4, 32'hABCD_0000, 32'h4, 1'b1, 1'b0);

    // Misaligned branch target
    step(0, 0, 0, 0, 0, 1, 32'h103, 32'h0);
    check_all(32'h100, 32'h0, 32'h0, 1'b0, ERR_EN);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    check_all(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Randomized run against the reference model
    for (int n = 0; n < 400; n++) begin
      t1 = $urandom; t2 = $urandom; t3 = $urandom;
      if ($urandom_range(3) != 0) t1[1:0] = 2'b00;
      if ($urandom_range(3) != 0) t2[1:0] = 2'b00;
      if ($urandom_range(3) != 0) t3[1:0] = 2'b00;
      step($urandom_range(49) == 0, $urandom_range(3) == 0, 2'($urandom_range(3)),
           t1, t2, $urandom_range(7) == 0, t3, $urandom);
      check_all(m_pc, m_inst, m_pcp4, m_valid, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
